// File: rtl/common_pkg.sv
// Shared link-layer types and constants: DLLP container, PIPE K-codes,
// RX deframer state encoding and DLLP CRC-16 parameters.
package common_pkg;

    typedef logic [5:0][7:0] dllp_t;

    localparam logic [7:0] K_SDP = 8'h5C;
    localparam logic [7:0] K_STP = 8'hFB;
    localparam logic [7:0] K_END = 8'hFD;
    localparam logic [7:0] K_EDB = 8'hFE;

    typedef logic [1:0] deframer_state_t;
    localparam deframer_state_t ST_IDLE     = 2'd0;
    localparam deframer_state_t ST_COLLECT  = 2'd1;
    localparam deframer_state_t ST_WAIT_END = 2'd2;
    localparam deframer_state_t ST_SKIP     = 2'd3;

    localparam logic [15:0] CRC_POLY = 16'h100B;
    localparam logic [15:0] CRC_SEED = 16'hFFFF;

endpackage

// File: rtl/dllp_crc16.sv
// Running DLLP CRC-16 (bit 0 of each byte first, inverted output).
// Only built when DLLP_CRC_CHECK_EN is defined.
`ifdef DLLP_CRC_CHECK_EN
module dllp_crc16
    import common_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        advance,
    input  logic [7:0]  data,
    output logic [15:0] crc
);

    logic [15:0] crc_reg;
    logic [15:0] crc_next;

    always_comb begin
        crc_next = crc_reg;
        for (int unsigned i = 0; i < 8; i++) begin
            if (crc_next[15] ^ data[i]) begin
                crc_next = {crc_next[14:0], 1'b0} ^ CRC_POLY;
            end else begin
                crc_next = {crc_next[14:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc_reg <= CRC_SEED;
        end else if (clear) begin
            crc_reg <= CRC_SEED;
        end else if (advance) begin
            crc_reg <= crc_next;
        end
    end

    assign crc = ~crc_reg;

endmodule
`endif

// File: rtl/pipe_dllp_rx_deframer.sv
// PIPE RX DLLP deframer: collects SDP-framed DLLPs, checks END/EDB framing,
// skips STP-framed TLPs. Optional CRC-16 check under DLLP_CRC_CHECK_EN.
module pipe_dllp_rx_deframer
    import common_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             pclk,
    input  logic             reset,
    input  logic             rx_valid,
    input  logic [7:0]       rx_data,
    input  logic             rx_datak,
    output logic             dllp_valid,
    output dllp_t            dllp_data,
    output logic             crc_err,
    output logic             frame_err,
    output logic             nullified,
    output logic [CNT_W-1:0] good_count,
    output logic [CNT_W-1:0] err_count
);

    deframer_state_t state, state_n;
    logic [2:0]      idx, idx_n;
    logic            wr_en;
    logic            sdp_seen;
    logic            ev_end;
    logic            ev_null;
    logic            ev_ferr;
    logic            crc_bad;

    always_comb begin
        state_n  = state;
        idx_n    = idx;
        wr_en    = 1'b0;
        sdp_seen = 1'b0;
        ev_end   = 1'b0;
        ev_null  = 1'b0;
        ev_ferr  = 1'b0;
        if (rx_valid) begin
            case (state)
                ST_IDLE: begin
                    if (rx_datak && rx_data == K_SDP) begin
                        state_n  = ST_COLLECT;
                        idx_n    = 3'd0;
                        sdp_seen = 1'b1;
                    end else if (rx_datak && rx_data == K_STP) begin
                        state_n = ST_SKIP;
                    end
                end
                ST_COLLECT: begin
                    if (!rx_datak) begin
                        wr_en = 1'b1;
                        if (idx == 3'd5) begin
                            state_n = ST_WAIT_END;
                            idx_n   = 3'd0;
                        end else begin
                            idx_n = idx + 3'd1;
                        end
                    end else if (rx_data == K_SDP) begin
                        ev_ferr  = 1'b1;
                        idx_n    = 3'd0;
                        sdp_seen = 1'b1;
                    end else if (rx_data == K_STP) begin
                        ev_ferr = 1'b1;
                        state_n = ST_SKIP;
                    end else if (rx_data == K_END || rx_data == K_EDB) begin
                        ev_ferr = 1'b1;
                        state_n = ST_IDLE;
                    end
                end
                ST_WAIT_END: begin
                    if (!rx_datak) begin
                        ev_ferr = 1'b1;
                        state_n = ST_IDLE;
                    end else if (rx_data == K_END) begin
                        ev_end  = 1'b1;
                        state_n = ST_IDLE;
                    end else if (rx_data == K_EDB) begin
                        ev_null = 1'b1;
                        state_n = ST_IDLE;
                    end else if (rx_data == K_STP) begin
                        ev_ferr = 1'b1;
                        state_n = ST_SKIP;
                    end else if (rx_data == K_SDP) begin
                        ev_ferr  = 1'b1;
                        state_n  = ST_COLLECT;
                        idx_n    = 3'd0;
                        sdp_seen = 1'b1;
                    end
                end
                default: begin
                    if (rx_datak && (rx_data == K_END || rx_data == K_EDB)) begin
                        state_n = ST_IDLE;
                    end else if (rx_datak && rx_data == K_SDP) begin
                        ev_ferr  = 1'b1;
                        state_n  = ST_COLLECT;
                        idx_n    = 3'd0;
                        sdp_seen = 1'b1;
                    end
                end
            endcase
        end
    end

`ifdef DLLP_CRC_CHECK_EN
    logic [15:0] crc_calc;

    // CRC covers bytes 0..3 only; bytes 4..5 carry the transmitted CRC.
    dllp_crc16 u_crc (
        .clk     (pclk),
        .rst     (reset),
        .clear   (sdp_seen),
        .advance (wr_en && idx < 3'd4),
        .data    (rx_data),
        .crc     (crc_calc)
    );

    assign crc_bad = (crc_calc != {dllp_data[4], dllp_data[5]});

    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            crc_err <= 1'b0;
        end else begin
            crc_err <= ev_end && crc_bad;
        end
    end
`else
    assign crc_bad = 1'b0;
    assign crc_err = 1'b0;
`endif

    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            idx        <= 3'd0;
            dllp_data  <= '0;
            dllp_valid <= 1'b0;
            frame_err  <= 1'b0;
            nullified  <= 1'b0;
            good_count <= '0;
            err_count  <= '0;
        end else begin
            state      <= state_n;
            idx        <= idx_n;
            dllp_valid <= ev_end;
            frame_err  <= ev_ferr;
            nullified  <= ev_null;
            if (wr_en) begin
                dllp_data[idx] <= rx_data;
            end
            if (ev_end && !crc_bad && good_count != '1) begin
                good_count <= good_count + CNT_W'(1);
            end
            if ((ev_ferr || ev_null || (ev_end && crc_bad)) && err_count != '1) begin
                err_count <= err_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipe_dllp_rx_deframer.sv
// Self-checking bench for pipe_dllp_rx_deframer: queue-level reference model
// compared every cycle, plus hand-computed literal checks.
module tb_pipe_dllp_rx_deframer;

    localparam int CW = 3;
`ifdef DLLP_CRC_CHECK_EN
    localparam bit CRC_ON = 1'b1;
`else
    localparam bit CRC_ON = 1'b0;
`endif

    logic          pclk = 1'b0;
    logic          reset = 1'b0;
    logic          rx_valid = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_datak = 1'b0;
    logic          dllp_valid;
    logic [47:0]   dllp_data;
    logic          crc_err;
    logic          frame_err;
    logic          nullified;
    logic [CW-1:0] good_count;
    logic [CW-1:0] err_count;

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    pipe_dllp_rx_deframer #(.CNT_W(CW)) dut (
        .pclk       (pclk),
        .reset      (reset),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_datak   (rx_datak),
        .dllp_valid (dllp_valid),
        .dllp_data  (dllp_data),
        .crc_err    (crc_err),
        .frame_err  (frame_err),
        .nullified  (nullified),
        .good_count (good_count),
        .err_count  (err_count)
    );

    always #5 pclk = ~pclk;

    function automatic logic [15:0] ref_crc(input logic [7:0] b0, b1, b2, b3);
        logic [31:0] s;
        logic [15:0] c;
        logic        fb;
        s = {b3, b2, b1, b0};
        c = 16'hFFFF;
        for (int k = 0; k < 32; k++) begin
            fb = c[15] ^ s[k];
            c  = {c[14:0], 1'b0} ^ (fb ? 16'h100B : 16'h0000);
        end
        return ~c;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a frame is either a DLLP being gathered, a TLP being skipped, or nothing.
    bit          m_dllp = 0, m_tlp = 0;
    int          m_n = 0;
    logic [7:0]  m_bytes [6] = '{default: 8'h00};
    bit          m_v = 0, m_c = 0, m_f = 0, m_nl = 0;
    logic [CW-1:0] m_good = '0, m_err = '0;
    bit          bad;

    always @(posedge pclk or posedge reset) begin
        if (reset) begin
            m_dllp = 0; m_tlp = 0; m_n = 0;
            for (int i = 0; i < 6; i++) m_bytes[i] = 8'h00;
            m_v = 0; m_c = 0; m_f = 0; m_nl = 0;
            m_good = '0; m_err = '0;
        end else begin
            m_v = 0; m_c = 0; m_f = 0; m_nl = 0;
            if (rx_valid) begin
                if (!rx_datak) begin
                    if (m_dllp) begin
                        if (m_n < 6) begin
                            m_bytes[m_n] = rx_data;
                            m_n++;
                        end else begin
                            m_f = 1; m_dllp = 0;
                        end
                    end
                end else if (rx_data == 8'h5C) begin
                    m_f = m_dllp || m_tlp;
                    m_dllp = 1; m_tlp = 0; m_n = 0;
                end else if (rx_data == 8'hFB) begin
                    m_f = m_dllp;
                    m_dllp = 0; m_tlp = 1;
                end else if (rx_data == 8'hFD || rx_data == 8'hFE) begin
                    if (m_dllp) begin
                        if (m_n == 6) begin
                            if (rx_data == 8'hFD) begin
                                bad = ref_crc(m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3])
                                      != {m_bytes[4], m_bytes[5]};
                                m_v = 1;
                                m_c = CRC_ON && bad;
                            end else begin
                                m_nl = 1;
                            end
                        end else begin
                            m_f = 1;
                        end
                    end
                    m_dllp = 0; m_tlp = 0;
                end
                if (m_v && !m_c && m_good != '1) m_good++;
                if ((m_f || m_nl || m_c) && m_err != '1) m_err++;
            end
        end
    end

    always @(negedge pclk) begin
        if (chk_on) begin
            chk("dllp_valid", 64'(dllp_valid), 64'(m_v));
            chk("crc_err", 64'(crc_err), 64'(m_c));
            chk("frame_err", 64'(frame_err), 64'(m_f));
            chk("nullified", 64'(nullified), 64'(m_nl));
            chk("dllp_data", 64'(dllp_data),
                64'({m_bytes[5], m_bytes[4], m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]}));
            chk("good_count", 64'(good_count), 64'(m_good));
            chk("err_count", 64'(err_count), 64'(m_err));
        end
    end

    task automatic sym(input logic k, input logic [7:0] d);
        @(posedge pclk); #1;
        rx_valid = 1'b1; rx_datak = k; rx_data = d;
    endtask

    // Stalls present a K SDP with rx_valid low; it must be ignored.
    task automatic gap(input int n);
        repeat (n) begin
            @(posedge pclk); #1;
            rx_valid = 1'b0; rx_datak = 1'b1; rx_data = 8'h5C;
        end
    endtask

    task automatic send_dllp(input logic [7:0] b0, b1, b2, b3, input logic flip, input logic [7:0] term);
        logic [15:0] c;
        c = ref_crc(b0, b1, b2, b3);
        sym(1, 8'h5C);
        sym(0, b0); sym(0, b1); sym(0, b2); sym(0, b3);
        sym(0, c[15:8]);
        sym(0, c[7:0] ^ (flip ? 8'h01 : 8'h00));
        sym(1, term);
    endtask

    logic [15:0] c0;

    initial begin
        c0 = ref_crc(8'h00, 8'h11, 8'h22, 8'h33);
        #2 reset = 1'b1;
        repeat (3) @(posedge pclk);
        #1 reset = 1'b0;
        chk_on = 1'b1;
        chk("rst_valid", 64'(dllp_valid), 64'd0);
        chk("rst_data", 64'(dllp_data), 64'd0);
        chk("rst_good", 64'(good_count), 64'd0);

        // good DLLP, latency 1 after END
        send_dllp(8'h00, 8'h11, 8'h22, 8'h33, 0, 8'hFD);
        gap(1);
        chk("t1_valid", 64'(dllp_valid), 64'd1);
        chk("t1_crc_err", 64'(crc_err), 64'd0);
        chk("t1_data_lo", 64'(dllp_data[31:0]), 64'h33221100);
        chk("t1_data_crc", 64'(dllp_data[47:32]), 64'({c0[7:0], c0[15:8]}));
        chk("t1_good", 64'(good_count), 64'd1);
        gap(1);
        chk("t1_pulse_drop", 64'(dllp_valid), 64'd0);

        // corrupted CRC byte 5
        send_dllp(8'h00, 8'h11, 8'h22, 8'h33, 1, 8'hFD);
        gap(1);
        chk("t2_valid", 64'(dllp_valid), 64'd1);
        chk("t2_crc_err", 64'(crc_err), 64'(CRC_ON));
        chk("t2_good", 64'(good_count), CRC_ON ? 64'd1 : 64'd2);
        chk("t2_err", 64'(err_count), CRC_ON ? 64'd1 : 64'd0);

        // stalls mid-packet
        sym(1, 8'h5C); sym(0, 8'h00); sym(0, 8'h11); gap(2);
        sym(0, 8'h22); sym(0, 8'h33); gap(1);
        sym(0, c0[15:8]); sym(0, c0[7:0]); sym(1, 8'hFD);
        gap(1);
        chk("t3_valid", 64'(dllp_valid), 64'd1);
        chk("t3_data", 64'(dllp_data), 64'({c0[7:0], c0[15:8], 32'h33221100}));

        // short DLLP ended by END
        sym(1, 8'h5C); sym(0, 8'hA1); sym(0, 8'hA2); sym(0, 8'hA3); sym(1, 8'hFD);
        gap(1);
        chk("t4_frame_err", 64'(frame_err), 64'd1);
        chk("t4_valid", 64'(dllp_valid), 64'd0);

        // nullified DLLP
        send_dllp(8'h01, 8'h02, 8'h03, 8'h04, 0, 8'hFE);
        gap(1);
        chk("t5_null", 64'(nullified), 64'd1);
        chk("t5_valid", 64'(dllp_valid), 64'd0);
        chk("t5_frame_err", 64'(frame_err), 64'd0);

        // back-to-back, ignored SKP/COM, data in WAIT_END, SDP in WAIT_END, STP in COLLECT
        send_dllp(8'h10, 8'h20, 8'h30, 8'h40, 0, 8'hFD);
        send_dllp(8'h50, 8'h60, 8'h70, 8'h80, 0, 8'hFD);
        sym(1, 8'h5C); sym(0, 8'h9A); sym(1, 8'h1C); sym(0, 8'h9B); sym(1, 8'hBC);
        sym(0, 8'h9C); sym(0, 8'h9D); sym(0, 8'h9E); sym(0, 8'h9F); sym(1, 8'hFD);
        send_dllp(8'h01, 8'h02, 8'h03, 8'h04, 0, 8'h00);
        send_dllp(8'h05, 8'h06, 8'h07, 8'h08, 0, 8'h5C);
        sym(0, 8'h11); sym(1, 8'hFB); sym(0, 8'h5C); sym(1, 8'hFE);
        gap(2);

        // TLP skipped, including a 5C data byte
        sym(1, 8'hFB);
        for (int i = 0; i < 20; i++) sym(0, (i == 7) ? 8'h5C : 8'(i * 13));
        sym(1, 8'hFD);
        gap(1);
        chk("t6_no_valid", 64'(dllp_valid), 64'd0);
        chk("t6_no_ferr", 64'(frame_err), 64'd0);
        send_dllp(8'hC0, 8'hC1, 8'hC2, 8'hC3, 0, 8'hFD);
        gap(1);
        chk("t6_valid", 64'(dllp_valid), 64'd1);

        // reset mid-frame
        sym(1, 8'h5C); sym(0, 8'hE0); sym(0, 8'hE1); sym(0, 8'hE2); sym(0, 8'hE3);
        @(posedge pclk); #1;
        rx_valid = 1'b0;
        reset = 1'b1;
        #2;
        chk("t7_rst_data", 64'(dllp_data), 64'd0);
        chk("t7_rst_pulses", 64'({dllp_valid, crc_err, frame_err, nullified}), 64'd0);
        chk("t7_rst_counts", 64'({good_count, err_count}), 64'd0);
        repeat (2) @(posedge pclk);
        #1 reset = 1'b0;
        send_dllp(8'hAA, 8'hBB, 8'hCC, 8'hDD, 0, 8'hFD);
        gap(1);
        chk("t7_valid", 64'(dllp_valid), 64'd1);
        chk("t7_ferr", 64'(frame_err), 64'd0);
        chk("t7_data_lo", 64'(dllp_data[31:0]), 64'hDDCCBBAA);
        chk("t7_good", 64'(good_count), 64'd1);

        // saturate good_count
        for (int i = 0; i < 8; i++)
            send_dllp(8'(i), 8'(i * 3), 8'(i * 7), 8'hF0, 0, 8'hFD);
        gap(2);
        chk("sat_good", 64'(good_count), 64'd7);
        chk("sat_err", 64'(err_count), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_dllp_rx_deframer.md
# pipe_dllp_rx_deframer

Receive-side DLLP deframer between the PIPE RX byte stream and the data-link layer. It scans 8-bit symbols (rx_data/rx_datak) for SDP-framed DLLPs and collects the 6 bytes into a dllp_t. It checks END/EDB framing and discards STP-framed TLP traffic. It is the counterpart of the transmit-side DLLP framer and drives the link-layer receive monitors.

## Interface
Parameters:
- CNT_W, 16, width of the saturating good/error counters.

Ports:
- pclk  input  1  PIPE clock; all logic is on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- rx_valid  input  1  rx_data/rx_datak carry a symbol this cycle.
- rx_data  input  8  received byte.
- rx_datak  input  1  1 = K-symbol.
- dllp_valid  output  1  one-cycle pulse: dllp_data holds a complete, correctly framed DLLP.
- dllp_data  output  dllp_t  captured DLLP; byte 0 is the first byte after SDP.
- crc_err  output  1  pulses with dllp_valid when the CRC check fails.
- frame_err  output  1  one-cycle pulse on a framing violation.
- nullified  output  1  one-cycle pulse when a DLLP ends in EDB.
- good_count  output  CNT_W  count of dllp_valid pulses with crc_err=0; saturates.
- err_count  output  CNT_W  count of frame_err, nullified and crc_err events; saturates.

## Operation
- K-codes: SDP=8'h5C, STP=8'hFB, END=8'hFD, EDB=8'hFE. All other K-symbols (COM, SKP, etc.) are ignored in every state and never count as a violation.
- Cycles with rx_valid=0 are stalls: no state, index or output change, except that pulses still drop.

State machine:
- IDLE
  - K SDP: go to COLLECT, idx=0.
  - K STP: go to SKIP.
  - Data bytes: ignored.
- COLLECT
  - Data byte: dllp_data[idx] is written.
  - After idx=5 is written: go to WAIT_END.
  - K SDP: frame_err; restart COLLECT with idx=0.
  - K STP: frame_err; go to SKIP.
  - K END or K EDB: frame_err; go to IDLE.
- WAIT_END
  - K END: raise dllp_valid (and crc_err if the check fails); go to IDLE.
  - K EDB: raise nullified; go to IDLE.
  - Data byte or K STP: frame_err; go to IDLE, or SKIP for STP.
  - K SDP: frame_err; go to COLLECT with idx=0.
- SKIP
  - K END or K EDB: go to IDLE.
  - K SDP: frame_err; go to COLLECT with idx=0.
  - Data bytes: ignored.
- Counter updates:
  - Each counter increments at most once per cycle.
  - Each counter holds at 2^CNT_W-1.
  - A frame_err and a crc_err cannot occur in the same cycle.
- dllp_data holds its value after dllp_valid until the next SDP. A partially collected DLLP may be visible while collecting; consumers only sample dllp_data on dllp_valid.

## Timing
- Reset values:
  - state = IDLE, idx = 0.
  - dllp_data = all zero.
  - dllp_valid, crc_err, frame_err, nullified = 0.
  - good_count, err_count = 0.
- Reset asserted mid-frame discards the partial DLLP with no error pulse.
- All outputs are registered.
- dllp_valid, crc_err, nullified and frame_err rise on the first pclk edge after the triggering symbol is sampled (latency 1). They last exactly one cycle.
- Back-to-back DLLPs (END followed directly by SDP) are accepted at full rate with no dead cycle.
- Counters update on the same edge as the corresponding pulse.

## Configuration
- DLLP_CRC_CHECK_EN defined:
  - CRC-16 is computed over bytes 0..3: polynomial 16'h100B, seed 16'hFFFF, each byte processed bit 0 first, result inverted.
  - The result is compared against byte 4 (crc[15:8]) and byte 5 (crc[7:0]).
  - A mismatch raises crc_err alongside dllp_valid and increments err_count instead of good_count.
- Undefined:
  - crc_err is tied to 0 and there is no CRC logic.
  - Every END-terminated DLLP counts as good.

## Structure
- Additions to common_pkg:
  - K-code constants K_SDP, K_STP, K_END, K_EDB.
  - The deframer state enum.
  - The CRC polynomial and seed constants.
- dllp_t is reused from common_pkg unchanged.
- Sub-module dllp_crc16, compiled only under DLLP_CRC_CHECK_EN. It is a combinational per-byte CRC step plus a running register, cleared on SDP and advanced on data bytes 0..3.

## Test plan
- SDP, bytes 00 11 22 33 + bench-computed CRC, END (macro defined) -> one dllp_valid one cycle after END; dllp_data = 00,11,22,33,crcH,crcL; crc_err=0; good_count=1.
- Same DLLP with byte 5 flipped -> dllp_valid=1, crc_err=1, err_count=1, good_count=0. Without the macro -> crc_err=0, good_count=1.
- SDP, 6 bytes, with rx_valid=0 on three cycles inserted mid-packet -> identical data; dllp_valid 1 cycle after END.
- SDP, 3 bytes, END -> frame_err pulse, no dllp_valid, err_count=1. SDP, 6 bytes, EDB -> nullified pulse only.
- STP, 20 data bytes including 5C as data, END, then a valid DLLP -> no pulses during the TLP; the DLLP is received normally.
- Reset asserted after SDP plus 4 bytes, released, then a valid DLLP -> all outputs zero during reset; no error pulse; the new DLLP is captured correctly.
